spi_slave_responder: RTL and testbench

SPI_SLAVE_RESPONDER -- requirements
Module: spi_slave_responder

---
 rtl/spi_slave_pkg.sv | 27 ++
 rtl/spi_slave_txfifo.sv | 76 +++++++
 rtl/spi_slave_responder.sv | 193 +++++++++++++++++++
 tb/tb_spi_slave_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : spi_slave_pkg
// Brief  : Shared FSM encoding, fill byte and CRC7 helpers for the SPI slave.
// Rev    : 1.0
// =============================================================================
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    localparam logic [7:0] C_FILL_BYTE = 8'hFF;
    localparam logic [6:0] C_CRC7_POLY = 7'h09;

    // One serial step of x^7+x^3+1, message bit entering at the top.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? C_CRC7_POLY : 7'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_txfifo.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : spi_slave_txfifo
// Brief  : Synchronous byte FIFO, 2**TXFIFO_LOG2 deep, count-based full/empty.
// Rev    : 1.0
// =============================================================================
module spi_slave_txfifo
    import spi_slave_pkg::*;
#(
    parameter int TXFIFO_LOG2 = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_pop,
    output logic [7:0] o_data,
    output logic       o_empty,
    output logic       o_ready
);

    localparam int                     C_DEPTH      = 1 << TXFIFO_LOG2;
    localparam logic [TXFIFO_LOG2:0]   C_FULL_COUNT = C_DEPTH[TXFIFO_LOG2:0];

    logic [7:0]             mem_q [C_DEPTH];
    logic [TXFIFO_LOG2-1:0] wr_ptr_q;
    logic [TXFIFO_LOG2-1:0] rd_ptr_q;
    logic [TXFIFO_LOG2:0]   count_q;
    logic [TXFIFO_LOG2:0]   count_d;
    logic                   ready_q;
    logic                   w_push;
    logic                   w_pop;

    assign w_push  = i_push & ready_q;
    assign w_pop   = i_pop & (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_empty = (count_q == '0);
    assign o_ready = ready_q;

    always_comb begin
        count_d = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (!w_push && w_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // ready_q tracks "not full" of the next cycle, so it is low throughout reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            ready_q <= (count_d != C_FULL_COUNT);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : spi_slave_responder
// Brief  : SPI mode-0 slave with TX FIFO, RX byte strobe and optional CRC7.
// Config : define SPI_SLAVE_CRC7_EN to enable the running CRC7 on o_crc7.
// Rev    : 1.0
// =============================================================================
module spi_slave_responder
    import spi_slave_pkg::*;
#(
    parameter int TXFIFO_LOG2 = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_spi_cs,
    input  logic       i_spi_sclk,
    input  logic       i_spi_mosi,
    output logic       o_spi_miso,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    output logic [7:0] o_rx_data,
    output logic       o_tx_underrun,
    output logic       o_busy,
    output logic [6:0] o_crc7
);

    logic cs_meta_q, cs_sync_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= i_spi_cs;
            cs_sync_q   <= cs_meta_q;
            sclk_meta_q <= i_spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= i_spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    logic w_cs_active;
    logic w_sclk_rise;
    logic w_sclk_fall;

    assign w_cs_active = ~cs_sync_q;
    assign w_sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign w_sclk_fall = ~sclk_sync_q & sclk_prev_q;

    logic       w_pop;
    logic [7:0] w_fifo_data;
    logic       w_fifo_empty;

    spi_slave_txfifo #(
        .TXFIFO_LOG2 (TXFIFO_LOG2)
    ) u_txfifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_tx_valid),
        .i_data  (i_tx_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_empty (w_fifo_empty),
        .o_ready (o_tx_ready)
    );

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       underrun_q, underrun_d;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        underrun_d = 1'b0;
        w_pop      = 1'b0;
        if (!w_cs_active) begin
            // Partial RX bits and any already-popped TX byte are dropped here.
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            rx_sr_d   = 8'h00;
            tx_sr_d   = C_FILL_BYTE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    w_pop = 1'b1;
                    if (w_fifo_empty) begin
                        tx_sr_d    = C_FILL_BYTE;
                        underrun_d = 1'b1;
                    end else begin
                        tx_sr_d = w_fifo_data;
                    end
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        rx_sr_d   = {rx_sr_q[6:0], mosi_sync_q};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d  = {rx_sr_q[6:0], mosi_sync_q};
                            rx_valid_d = 1'b1;
                            state_d    = ST_LOAD;
                        end
                    end else if (w_sclk_fall && (bit_cnt_q != 3'd0)) begin
                        // The fall after a byte's last rise must keep the freshly loaded MSB.
                        tx_sr_d = {tx_sr_q[6:0], 1'b1};
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            tx_sr_q    <= C_FILL_BYTE;
            rx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_spi_miso    = (state_q == ST_IDLE) | tx_sr_q[7];
    assign o_rx_valid    = rx_valid_q;
    assign o_rx_data     = rx_data_q;
    assign o_tx_underrun = underrun_q;
    assign o_busy        = w_cs_active;

`ifdef SPI_SLAVE_CRC7_EN
    logic       cs_prev_q;
    logic [6:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (cs_prev_q && !cs_sync_q) begin
            crc_d = 7'h00;
        end else if ((state_q == ST_SHIFT) && w_cs_active && w_sclk_rise) begin
            crc_d = crc7_step(crc_q, mosi_sync_q);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cs_prev_q <= 1'b1;
            crc_q     <= 7'h00;
        end else begin
            cs_prev_q <= cs_sync_q;
            crc_q     <= crc_d;
        end
    end

    assign o_crc7 = crc_q;
`else
    assign o_crc7 = 7'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// Module : tb_spi_slave_responder
// Brief  : Scoreboard bench for spi_slave_responder with a queue-based FIFO model.
// Rev    : 1.0
// =============================================================================
module tb_spi_slave_responder;

    localparam int DEPTH = 4;
    localparam int HALF  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cs = 1'b1;
    logic       sclk = 1'b0;
    logic       mosi = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso;
    logic       tx_ready;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       underrun;
    logic       busy;
    logic [6:0] crc7;

    always #5 clk = ~clk;

    spi_slave_responder #(
        .TXFIFO_LOG2 (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_spi_cs      (cs),
        .i_spi_sclk    (sclk),
        .i_spi_mosi    (mosi),
        .o_spi_miso    (miso),
        .i_tx_valid    (tx_valid),
        .i_tx_data     (tx_data),
        .o_tx_ready    (tx_ready),
        .o_rx_valid    (rx_valid),
        .o_rx_data     (rx_data),
        .o_tx_underrun (underrun),
        .o_busy        (busy),
        .o_crc7        (crc7)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] fifo_model[$];
    logic [7:0] rx_exp[$];
    int         und_seen = 0;
    int         und_exp  = 0;
    logic [6:0] crc_model = 7'h00;
    logic [7:0] mosi_bytes[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every RX strobe must match the oldest expected byte.
    always @(negedge clk) begin
        if (rx_valid) begin
            if (rx_exp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %0h expected no strobe", rx_data);
            end else begin
                check("rx_data", {24'h0, rx_data}, {24'h0, rx_exp.pop_front()});
            end
        end
        if (underrun) und_seen++;
    end

    task automatic model_pop(output logic [7:0] b);
        if (fifo_model.size() == 0) begin
            und_exp++;
            b = 8'hFF;
        end else begin
            b = fifo_model.pop_front();
        end
    endtask

    task automatic crc_bit(input logic b);
        logic fb;
        fb = crc_model[6] ^ b;
        crc_model = {crc_model[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        check("tx_ready", {31'h0, tx_ready}, {31'h0, fifo_model.size() < DEPTH});
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        if (fifo_model.size() < DEPTH) fifo_model.push_back(b);
    endtask

    task automatic transfer(input int nfull, input int tail);
        logic [7:0] exp_miso;
        logic [7:0] got;
        logic [7:0] sh;
        int         nb;
        int         nbits;
        @(negedge clk);
        #2;
        cs = 1'b0;
        crc_model = 7'h00;
        #(2 * HALF);
        check("busy_active", {31'h0, busy}, 32'd1);
        nb = nfull + ((tail > 0) ? 1 : 0);
        for (int k = 0; k < nb; k++) begin
            nbits = (k < nfull) ? 8 : tail;
            model_pop(exp_miso);
            sh  = mosi_bytes[k];
            got = 8'h00;
            for (int i = 0; i < nbits; i++) begin
                mosi = sh[7];
                #HALF;
                if (i == 0) check("underrun_count", und_seen, und_exp);
                got = {got[6:0], miso};
                if (i == 7) rx_exp.push_back(mosi_bytes[k]);
                crc_bit(sh[7]);
                sh = {sh[6:0], 1'b0};
                sclk = 1'b1;
                #HALF;
                sclk = 1'b0;
            end
            if (nbits == 8) check("miso_byte", {24'h0, got}, {24'h0, exp_miso});
            else check("miso_partial", {24'h0, got}, {24'h0, exp_miso >> (8 - nbits)});
        end
        if (tail == 0) model_pop(exp_miso);
        #HALF;
        cs = 1'b1;
        #100;
        check("busy_idle", {31'h0, busy}, 32'd0);
        check("miso_idle", {31'h0, miso}, 32'd1);
        check("underrun_total", und_seen, und_exp);
`ifdef SPI_SLAVE_CRC7_EN
        check("crc7", {25'h0, crc7}, {25'h0, crc_model});
`else
        check("crc7_tied", {25'h0, crc7}, 32'd0);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_ready"}, {31'h0, tx_ready}, 32'd0);
        check({tag, "_rx_valid"}, {31'h0, rx_valid}, 32'd0);
        check({tag, "_rx_data"},  {24'h0, rx_data},  32'd0);
        check({tag, "_underrun"}, {31'h0, underrun}, 32'd0);
        check({tag, "_busy"},     {31'h0, busy},     32'd0);
        check({tag, "_crc7"},     {25'h0, crc7},     32'd0);
        check({tag, "_miso"},     {31'h0, miso},     32'd1);
    endtask

    initial begin
        logic [7:0] dummy;
        int         npush;
        int         nfull;
        int         tail;

        #23;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tx_ready_after_reset", {31'h0, tx_ready}, 32'd1);

        // Basic byte exchange
        push(8'hA5);
        mosi_bytes[0] = 8'h3C;
        transfer(1, 0);

        // Empty FIFO sends the fill byte
        mosi_bytes[0] = 8'h81;
        transfer(1, 0);

        // Fill to depth, overflow push ignored, back-to-back bytes
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        @(negedge clk);
        check("tx_ready_full", {31'h0, tx_ready}, 32'd0);
        push(8'h99);
        mosi_bytes[0] = 8'hC3;
        mosi_bytes[1] = 8'h5A;
        mosi_bytes[2] = 8'h0F;
        transfer(3, 0);

        // CS raised mid-byte, next transfer sends the following entry
        push(8'h55);
        push(8'h66);
        mosi_bytes[0] = 8'hF0;
        transfer(0, 5);
        mosi_bytes[0] = 8'h12;
        transfer(1, 0);

        // CMD0 frame
        mosi_bytes[0] = 8'h40;
        for (int k = 1; k < 5; k++) mosi_bytes[k] = 8'h00;
        transfer(5, 0);
`ifdef SPI_SLAVE_CRC7_EN
        check("crc7_cmd0", {25'h0, crc7}, 32'h4A);
`else
        check("crc7_cmd0_tied", {25'h0, crc7}, 32'h0);
`endif

        // Reset in the middle of a byte
        push(8'h77);
        push(8'h88);
        @(negedge clk);
        #2;
        cs = 1'b0;
        #(2 * HALF);
        model_pop(dummy);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            #HALF;
            sclk = 1'b1;
            #HALF;
            sclk = 1'b0;
        end
        #13;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        fifo_model.delete();
        cs = 1'b1;
        #50;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tx_ready_after_midreset", {31'h0, tx_ready}, 32'd1);
        mosi_bytes[0] = 8'h6E;
        transfer(1, 0);

        // Randomized transfers
        for (int it = 0; it < 12; it++) begin
            npush = $urandom_range(0, 5);
            for (int p = 0; p < npush; p++) push(8'($urandom));
            nfull = $urandom_range(0, 3);
            tail  = $urandom_range(0, 7);
            if (nfull == 0 && tail == 0) nfull = 1;
            for (int k = 0; k < 8; k++) mosi_bytes[k] = 8'($urandom);
            transfer(nfull, tail);
        end

        repeat (10) @(negedge clk);
        check("rx_pending", rx_exp.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
